fo4_ring_freq_meter: RTL
========================

Name: fo4_ring_freq_meter

Overview:
- Measurement back end for the FO4 inverter ring oscillator: consumes the ring's loop output (or a probe tap) and reports oscillation statistics in the system clock domain.
- Gates the ring via an enable output.
- Synchronizes the asynchronous ring signal, then counts its rising edges and high cycles over a programmable window of clk cycles.
- Returns results through a valid/ready handshake; software derives FO4 delay from edge count, window length and stage count.

Parameters:
- CNT_W, 16, width of edge_count; saturating.
- WIN_W, 16, width of window_len and high_count.
- SYNC_STAGES, 2, flops in ring_in synchronizer (>=2).
- SETTLE, 4, clk cycles ring runs after enable before the window opens (>= SYNC_STAGES+1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low).
- start  input  1  request a measurement; sampled only in IDLE.
- window_len  input  WIN_W  measurement window in clk cycles; latched on accepted start.
- ring_in  input  1  asynchronous ring-oscillator output; required frequency < clk/2.
- osc_enable  output  1  enables the ring loop.
- busy  output  1  high in ARM and MEASURE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- edge_count  output  CNT_W  rising edges of synchronized ring_in inside the window.
- high_count  output  WIN_W  window cycles with synchronized ring_in = 1.
- overflow  output  1  edge_count or high_count saturated.

Behaviour:
- Reset (async, any state): state=IDLE; osc_enable, busy, res_valid, overflow = 0; edge_count, high_count = 0; synchronizer and edge-detect flops = 0.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - start=1 at edge t: latch window_len into win_q, clear counters and overflow, go to ARM.
  - start=0: stay in IDLE.
- ARM:
  - osc_enable=1, busy=1; settle counter runs SETTLE cycles.
  - Synchronizer and edge-detect history update normally; no counting.
  - If win_q==0, go directly from ARM to DONE with zero counts.
  - Otherwise go to MEASURE.
- MEASURE:
  - Lasts exactly win_q cycles; osc_enable=1, busy=1.
  - Each cycle: high_count += s (synchronized level); edge_count += (s & ~s_prev).
  - Each counter saturates at all-ones independently; saturation sets overflow (sticky until next start).
  - After the last cycle go to DONE.
- DONE:
  - res_valid=1, osc_enable=0, busy=0.
  - Outputs stay stable while res_valid=1 & res_ready=0.
  - On res_valid & res_ready go to IDLE; res_valid=0 the next cycle. Counts remain readable until the next accepted start.
- Latency: res_valid rises SETTLE+win_q+1 edges after the accepting edge t.
- start outside IDLE is ignored, not queued; this includes the DONE cycle in which the handshake completes.
- res_ready outside DONE has no effect.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; any partial result is discarded.
- ring_in is used only after SYNC_STAGES flops; no combinational path from ring_in to any output.

Decomposition:
- Package fo4_meas_pkg holds:
  - state enum (IDLE/ARM/MEASURE/DONE);
  - default SETTLE and SYNC_STAGES constants;
  - saturating-increment function.
- Sub-module fo4_sync_edge, parameterized by SYNC_STAGES:
  - inputs clk, rst_n, async_in;
  - outputs level s and rise pulse (s & ~s_prev).
- FSM and counters stay in fo4_ring_freq_meter.

Test Plan:
- Basic: ring_in = clk/8 square wave (4 high, 4 low), window_len=64, start pulse -> res_valid after 4+64+1 edges; edge_count=8, high_count=32, overflow=0.
- Backpressure: same stimulus, res_ready held 0 for 20 cycles -> outputs stable, res_valid stays 1; start pulses meanwhile ignored; res_ready=1 -> IDLE, res_valid=0 next cycle.
- Zero window: window_len=0 -> DONE after SETTLE cycles; edge_count=0, high_count=0; osc_enable high for exactly 4 cycles.
- Saturation: CNT_W=3, ring clk/4, window_len=64 -> edge_count=7, overflow=1, high_count=32.
- Busy re-start: start re-asserted during MEASURE with a different window_len -> ignored; result reflects the original window.
- Reset mid-measure: rst_n low 3 cycles during MEASURE -> osc_enable, busy, res_valid, counts = 0 immediately (asynchronously); new start afterwards gives the correct clk/8 result.

Source files
------------

// File: rtl/fo4_meas_pkg.sv
// Shared definitions for the FO4 ring-oscillator frequency meter.
//   meas_state_e      : measurement FSM states
//   DefaultSettle     : default ring settle time in clk cycles
//   DefaultSyncStages : default depth of the ring_in synchronizer
//   sat_inc()         : saturating increment on values up to 32 bits wide
package fo4_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure,
    StDone
  } meas_state_e;

  localparam int unsigned DefaultSettle     = 4;
  localparam int unsigned DefaultSyncStages = 2;

  // Returns val+1 when inc is set, holding at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    return (inc && (val != max_val)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/fo4_sync_edge.sv
// Synchronizer plus rising-edge detector for the asynchronous ring signal.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_in   : asynchronous input (ring oscillator output)
//   s          : synchronized level (output of the last synchronizer flop)
//   rise       : one-cycle pulse where s is 1 and was 0 the cycle before
module fo4_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/fo4_ring_freq_meter.sv
// Measurement back end for the FO4 inverter ring oscillator.
// Enables the ring, lets it settle, then counts rising edges and high cycles of
// the synchronized ring signal over a window of clk cycles and hands the result
// out on a valid/ready interface.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   start        : request a measurement (honoured only while idle)
//   window_len   : window length in clk cycles, captured when start is accepted
//   ring_in      : asynchronous ring output (must be slower than clk/2)
//   osc_enable   : ring loop enable, high while arming and measuring
//   busy         : high while arming and measuring
//   res_valid    : result available; res_ready accepts it
//   edge_count   : rising edges inside the window (saturating)
//   high_count   : window cycles with the ring high (saturating)
//   overflow     : sticky flag, a counter tried to go past all-ones
// Requires CNT_W, WIN_W <= 32 and SETTLE >= SYNC_STAGES+1.
module fo4_ring_freq_meter
  import fo4_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned SETTLE      = DefaultSettle
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic             ring_in,
  output logic             osc_enable,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] edge_count,
  output logic [WIN_W-1:0] high_count,
  output logic             overflow
);

  localparam int unsigned    SetW       = $clog2(SETTLE + 1);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [WIN_W-1:0] HighMax   = '1;

  meas_state_e      state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] meas_q, meas_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [WIN_W-1:0] high_q, high_d;
  logic             ovf_q, ovf_d;
  logic             osc_q, osc_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             ring_s, ring_rise;

  fo4_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(ring_in),
    .s       (ring_s),
    .rise    (ring_rise)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    meas_d   = meas_q;
    settle_d = settle_q;
    edge_d   = edge_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_d    = window_len;
          edge_d   = '0;
          high_d   = '0;
          ovf_d    = 1'b0;
          settle_d = '0;
          state_d  = StArm;
        end
      end
      StArm: begin
        settle_d = settle_q + SetW'(1);
        if (settle_q == SettleLast) begin
          meas_d  = '0;
          state_d = (win_q == '0) ? StDone : StMeasure;
        end
      end
      StMeasure: begin
        meas_d = meas_q + WIN_W'(1);
        edge_d = CNT_W'(sat_inc(32'(edge_q), 32'(CntMax), ring_rise));
        high_d = WIN_W'(sat_inc(32'(high_q), 32'(HighMax), ring_s));
        if ((ring_rise && (edge_q == CntMax)) || (ring_s && (high_q == HighMax))) begin
          ovf_d = 1'b1;
        end
        if (meas_q == win_q - WIN_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // res_valid comes up one cycle after entering DONE and drops on handshake.
        valid_d = 1'b1;
        if (valid_q && res_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Enable and busy follow the next state so the ring runs for the full settle time.
    osc_d  = (state_d == StArm) || (state_d == StMeasure);
    busy_d = osc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      win_q    <= '0;
      meas_q   <= '0;
      settle_q <= '0;
      edge_q   <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      osc_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      meas_q   <= meas_d;
      settle_q <= settle_d;
      edge_q   <= edge_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      osc_q    <= osc_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign osc_enable = osc_q;
  assign busy       = busy_q;
  assign res_valid  = valid_q;
  assign edge_count = edge_q;
  assign high_count = high_q;
  assign overflow   = ovf_q;

endmodule
